router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the 3-port router ingress: drives data_in/pkt_valid and honours busy.
//  Host loads payload bytes into an internal buffer, then starts with a destination address.
//  Block sends header {len[5:0],addr[1:0]}, the payload bytes, then the XOR parity byte.
//  It samples router err after parity and reports status. Used in benches and as the on-chip packet source.
// PARAMETERS
//  MAX_LEN     63  buffer depth / max payload bytes (1..63, fits 6-bit length field)
//  GAP_CYCLES  2   min idle cycles after parity before next start (>=1)
// PORTS
//  clock        in   1  single clock, all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  wr_en        in   1  push wr_data into payload buffer (IDLE only)
//  wr_data      in   8  payload byte
//  buf_count    out  7  bytes currently buffered
//  buf_full     out  1  buf_count == MAX_LEN
//  start        in   1  request transmission of buffered payload
//  dest_addr    in   2  destination port, sampled with start
//  start_ready  out  1  high in IDLE only
//  start_err    out  1  1-cycle pulse: start rejected
//  pkt_data     out  8  to router data_in (registered)
//  pkt_valid    out  1  to router pkt_valid (registered)
//  busy         in   1  router busy
//  err          in   1  router parity error
//  pkt_done     out  1  1-cycle pulse: packet finished
//  pkt_err      out  1  router err seen for last packet, valid with pkt_done
// BEHAVIOUR
//  Reset: state IDLE, buf_count=0, pkt_data=0, pkt_valid=0, start_err=0, pkt_done=0, pkt_err=0.
//   start_ready=1. Reset mid-packet aborts at the next edge and discards buffer contents.
//  FSM: IDLE -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE.
//  IDLE: wr_en && !buf_full writes buffer[buf_count] and increments count. wr_en while full is ignored.
//   start: if dest_addr==2'b11 or buf_count==0, pulse start_err and stay IDLE.
//   Otherwise latch len=buf_count and addr, clear pkt_err, go HEADER.
//   start and wr_en in the same cycle: start wins, write dropped. wr_en outside IDLE is ignored.
//  Start accepted at edge N: header on pkt_data with pkt_valid=1 from cycle N+1.
//  HEADER/PAYLOAD: a beat is consumed at an edge where busy==0. The next byte loads on that edge.
//   While busy==1, pkt_data/pkt_valid hold; no skip, no duplicate.
//  Read pointer is 6-bit; running parity = header ^ all payload bytes, updated per consumed beat.
//  Last payload beat consumed at edge M: cycle M+1 presents parity with pkt_valid=0 (PARITY, exactly 1 cycle, not gated by busy).
//   pkt_data then holds the parity value.
//  GAP: >= GAP_CYCLES cycles, then exit only when busy==0.
//   pkt_err = OR of err over the PARITY and GAP cycles.
//  On exit to IDLE: pkt_done pulses 1 cycle, buf_count clears to 0, pkt_err holds until next accepted start.
//  pkt_valid never high outside HEADER/PAYLOAD. No bubbles inside a packet: the whole payload is buffered before start.
// CONFIGURATION
//  ROUTER_TX_PARITY_INJ_EN defined: extra input inj_parity (1b), sampled with an accepted start.
//   If it was 1, the transmitted parity byte is bitwise inverted (error injection).
//  Undefined: port absent, parity always correct.
// TESTING
//  1 Load 0x11,0x22,0x33; start addr=1; busy=0 -> pkt_data 0x0D,0x11,0x22,0x33 (pkt_valid=1), then 0x0D (pkt_valid=0); pkt_done, pkt_err=0.
//  2 As 1, busy=1 for 2 cycles while 0x22 shown -> 0x22 held 3 cycles, then 0x33, parity 0x0D; no dup/skip.
//  3 start with dest_addr=3, or with buf_count=0 -> start_err 1-cycle pulse, pkt_valid stays 0, buffer intact.
//  4 Write 64 bytes -> buf_count=63, buf_full=1, 64th ignored; start addr=2 -> header 0xFE, 63 payload beats.
//  5 reset=1 for 1 cycle mid-PAYLOAD -> next cycle pkt_valid=0, buf_count=0, start_ready=1.
//  6 (ROUTER_TX_PARITY_INJ_EN) test 1 with inj_parity=1 -> parity 0xF2; router err -> pkt_err=1 at pkt_done.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Host/router signal bundle for router_pkt_tx. slave = packet source view, master = host/router view.
// ROUTER_TX_PARITY_INJ_EN adds the inj_parity control.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [6:0] buf_count;
    logic       buf_full;
    logic       start;
    logic [1:0] dest_addr;
    logic       start_ready;
    logic       start_err;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       busy;
    logic       err;
    logic       pkt_done;
    logic       pkt_err;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       inj_parity;
`endif

    modport slave (
`ifdef ROUTER_TX_PARITY_INJ_EN
        input  inj_parity,
`endif
        input  wr_en, wr_data, start, dest_addr, busy, err,
        output buf_count, buf_full, start_ready, start_err,
        output pkt_data, pkt_valid, pkt_done, pkt_err
    );

    modport master (
`ifdef ROUTER_TX_PARITY_INJ_EN
        output inj_parity,
`endif
        output wr_en, wr_data, start, dest_addr, busy, err,
        input  buf_count, buf_full, start_ready, start_err,
        input  pkt_data, pkt_valid, pkt_done, pkt_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router ingress packet source: buffers payload, sends header/payload/parity, reports router err.
// Optional feature macro: ROUTER_TX_PARITY_INJ_EN (inverts the parity byte when inj_parity is set at start).
module router_pkt_tx #(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic             i_clock,
    input logic             i_reset,
    router_pkt_tx_if.slave  bus
);
    localparam logic [6:0] MAX_CNT  = 7'(MAX_LEN);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_buf [MAX_LEN];
    logic [6:0] r_count, w_count_nxt;
    logic [5:0] r_len, w_len_nxt;
    logic [5:0] r_rdptr, w_rdptr_nxt;
    logic [7:0] r_parity, w_parity_nxt;
    logic [7:0] r_pkt_data, w_pkt_data_nxt;
    logic       r_pkt_valid, w_pkt_valid_nxt;
    logic       r_start_err, w_start_err_nxt;
    logic       r_pkt_done, w_pkt_done_nxt;
    logic       r_pkt_err, w_pkt_err_nxt;
    logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
    logic       w_wr;
    logic [7:0] w_hdr;
    logic [7:0] w_rd_byte;
    logic [7:0] w_par_out;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       r_inj, w_inj_nxt;
`endif

    assign w_hdr     = {r_count[5:0], bus.dest_addr};
    assign w_rd_byte = r_buf[r_rdptr];
`ifdef ROUTER_TX_PARITY_INJ_EN
    assign w_par_out = r_parity ^ {8{r_inj}};
`else
    assign w_par_out = r_parity;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_len_nxt       = r_len;
        w_rdptr_nxt     = r_rdptr;
        w_parity_nxt    = r_parity;
        w_pkt_data_nxt  = r_pkt_data;
        w_pkt_valid_nxt = r_pkt_valid;
        w_start_err_nxt = 1'b0;
        w_pkt_done_nxt  = 1'b0;
        w_pkt_err_nxt   = r_pkt_err;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_wr            = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        w_inj_nxt       = r_inj;
`endif
        case (r_state)
            S_IDLE: begin
                // start has priority over a same-cycle write
                if (bus.start) begin
                    if (bus.dest_addr == 2'b11 || r_count == '0) begin
                        w_start_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_HEADER;
                        w_len_nxt       = r_count[5:0];
                        w_rdptr_nxt     = '0;
                        w_parity_nxt    = w_hdr;
                        w_pkt_data_nxt  = w_hdr;
                        w_pkt_valid_nxt = 1'b1;
                        w_pkt_err_nxt   = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
                        w_inj_nxt       = bus.inj_parity;
`endif
                    end
                end else if (bus.wr_en && r_count != MAX_CNT) begin
                    w_wr        = 1'b1;
                    w_count_nxt = r_count + 7'd1;
                end
            end
            S_HEADER: begin
                if (!bus.busy) begin
                    w_state_nxt    = S_PAYLOAD;
                    w_pkt_data_nxt = w_rd_byte;
                    w_parity_nxt   = r_parity ^ w_rd_byte;
                    w_rdptr_nxt    = r_rdptr + 6'd1;
                end
            end
            S_PAYLOAD: begin
                // parity already holds every loaded byte once the pointer reaches len
                if (!bus.busy) begin
                    if (r_rdptr == r_len) begin
                        w_state_nxt     = S_PARITY;
                        w_pkt_valid_nxt = 1'b0;
                        w_pkt_data_nxt  = w_par_out;
                    end else begin
                        w_pkt_data_nxt = w_rd_byte;
                        w_parity_nxt   = r_parity ^ w_rd_byte;
                        w_rdptr_nxt    = r_rdptr + 6'd1;
                    end
                end
            end
            S_PARITY: begin
                w_pkt_err_nxt = r_pkt_err | bus.err;
                w_gap_cnt_nxt = '0;
                w_state_nxt   = S_GAP;
            end
            S_GAP: begin
                w_pkt_err_nxt = r_pkt_err | bus.err;
                if (r_gap_cnt >= GAP_LAST && !bus.busy) begin
                    w_state_nxt    = S_IDLE;
                    w_pkt_done_nxt = 1'b1;
                    w_count_nxt    = '0;
                end else if (r_gap_cnt < GAP_LAST) begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_len       <= '0;
            r_rdptr     <= '0;
            r_parity    <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_start_err <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_gap_cnt   <= '0;
`ifdef ROUTER_TX_PARITY_INJ_EN
            r_inj       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_len       <= w_len_nxt;
            r_rdptr     <= w_rdptr_nxt;
            r_parity    <= w_parity_nxt;
            r_pkt_data  <= w_pkt_data_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_start_err <= w_start_err_nxt;
            r_pkt_done  <= w_pkt_done_nxt;
            r_pkt_err   <= w_pkt_err_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
`ifdef ROUTER_TX_PARITY_INJ_EN
            r_inj       <= w_inj_nxt;
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_wr) begin
            r_buf[r_count[5:0]] <= bus.wr_data;
        end
    end

    assign bus.buf_count   = r_count;
    assign bus.buf_full    = (r_count == MAX_CNT);
    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.start_err   = r_start_err;
    assign bus.pkt_data    = r_pkt_data;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_done    = r_pkt_done;
    assign bus.pkt_err     = r_pkt_err;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx against a byte-list model of the expected packet stream.
module tb_router_pkt_tx;
    localparam int unsigned MAX_LEN    = 63;
    localparam int unsigned GAP_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] q_buf [$];

    router_pkt_tx_if bus ();

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.dest_addr = '0;
        bus.busy      = 1'b0;
        bus.err       = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        bus.inj_parity = 1'b0;
`endif
    endtask

    task automatic load_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en = 1'b0;
        if (q_buf.size() < MAX_LEN) q_buf.push_back(b);
    endtask

    task automatic check_buf;
        chk("buf_count", 32'(bus.buf_count), 32'(q_buf.size()));
        chk("buf_full", 32'(bus.buf_full), 32'(q_buf.size() == MAX_LEN));
    endtask

    // Expected stream: header {len,addr}, buffered bytes, then XOR of all of them.
    task automatic xmit(input logic [1:0] addr, input int busy_pct, input int err_pct, input bit inj);
        logic [7:0] exp_bytes [$];
        logic [7:0] par;
        bit         exp_err;
        bit         exp_done;
        bit         b;
        bit         e;
        int         idx;
        int         guard;
        int         g;
        exp_bytes.push_back({6'(q_buf.size()), addr});
        foreach (q_buf[i]) exp_bytes.push_back(q_buf[i]);
        par = '0;
        foreach (exp_bytes[i]) par = par ^ exp_bytes[i];
        if (inj) par = ~par;

        bus.start     = 1'b1;
        bus.dest_addr = addr;
        bus.wr_en     = 1'($urandom_range(0, 1));
        bus.wr_data   = 8'($urandom);
`ifdef ROUTER_TX_PARITY_INJ_EN
        bus.inj_parity = inj;
`endif
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("ready_low", 32'(bus.start_ready), 32'd0);
        chk("err_clear", 32'(bus.pkt_err), 32'd0);

        idx   = 0;
        guard = 0;
        while (idx < exp_bytes.size()) begin
            chk("beat_valid", 32'(bus.pkt_valid), 32'd1);
            chk("beat_data", 32'(bus.pkt_data), 32'(exp_bytes[idx]));
            b = (guard < 400) && ($urandom_range(0, 99) < busy_pct);
            bus.busy    = b;
            bus.err     = ($urandom_range(0, 99) < err_pct);
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_data = 8'($urandom);
            tick();
            if (!b) idx++;
            guard++;
        end

        chk("par_valid", 32'(bus.pkt_valid), 32'd0);
        chk("par_data", 32'(bus.pkt_data), 32'(par));
        e = ($urandom_range(0, 99) < err_pct);
        bus.err  = e;
        bus.busy = 1'($urandom_range(0, 1));
        exp_err  = e;
        tick();

        g = 0;
        for (int k = 0; k < 100; k++) begin
            chk("gap_valid", 32'(bus.pkt_valid), 32'd0);
            chk("gap_data", 32'(bus.pkt_data), 32'(par));
            b = (k < 50) && ($urandom_range(0, 99) < busy_pct + 20);
            e = ($urandom_range(0, 99) < err_pct);
            bus.busy = b;
            bus.err  = e;
            exp_err  = exp_err | e;
            exp_done = (g + 1 >= GAP_CYCLES) && !b;
            tick();
            chk("pkt_done", 32'(bus.pkt_done), 32'(exp_done));
            if (exp_done) break;
            g++;
        end

        chk("pkt_err", 32'(bus.pkt_err), 32'(exp_err));
        chk("done_count", 32'(bus.buf_count), 32'd0);
        chk("done_ready", 32'(bus.start_ready), 32'd1);
        q_buf.delete();
        idle_inputs();
        tick();
        chk("done_pulse", 32'(bus.pkt_done), 32'd0);
        chk("err_hold", 32'(bus.pkt_err), 32'(exp_err));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_count", 32'(bus.buf_count), 32'd0);
        chk("rst_valid", 32'(bus.pkt_valid), 32'd0);
        chk("rst_data", 32'(bus.pkt_data), 32'd0);
        chk("rst_serr", 32'(bus.start_err), 32'd0);
        chk("rst_done", 32'(bus.pkt_done), 32'd0);
        chk("rst_perr", 32'(bus.pkt_err), 32'd0);
        rst = 1'b0;
        tick();

        // start with an empty buffer
        bus.start = 1'b1;
        bus.dest_addr = 2'd0;
        tick();
        bus.start = 1'b0;
        chk("empty_serr", 32'(bus.start_err), 32'd1);
        chk("empty_valid", 32'(bus.pkt_valid), 32'd0);
        chk("empty_ready", 32'(bus.start_ready), 32'd1);
        tick();
        chk("serr_pulse", 32'(bus.start_err), 32'd0);

        // directed 0x11,0x22,0x33 to port 1, then the same with busy stalls and err
        for (int r = 0; r < 2; r++) begin
            load_byte(8'h11);
            load_byte(8'h22);
            load_byte(8'h33);
            check_buf();
            xmit(2'd1, (r == 0) ? 0 : 50, (r == 0) ? 0 : 20, 1'b0);
        end

        // bad address is rejected and the buffer survives
        for (int i = 0; i < 3; i++) load_byte(8'($urandom));
        bus.start = 1'b1;
        bus.dest_addr = 2'd3;
        tick();
        bus.start = 1'b0;
        chk("addr3_serr", 32'(bus.start_err), 32'd1);
        chk("addr3_valid", 32'(bus.pkt_valid), 32'd0);
        check_buf();
        tick();
        chk("addr3_pulse", 32'(bus.start_err), 32'd0);
        xmit(2'd2, 30, 10, 1'b0);

        // overfill: 64 writes keep 63
        for (int i = 0; i < 64; i++) load_byte(8'($urandom));
        check_buf();
        xmit(2'd2, 20, 0, 1'b0);

        // reset in the middle of the payload
        for (int i = 0; i < 10; i++) load_byte(8'($urandom));
        bus.start = 1'b1;
        bus.dest_addr = 2'd0;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("mid_valid_pre", 32'(bus.pkt_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_buf.delete();
        chk("mid_valid", 32'(bus.pkt_valid), 32'd0);
        chk("mid_count", 32'(bus.buf_count), 32'd0);
        chk("mid_ready", 32'(bus.start_ready), 32'd1);
        load_byte(8'hA5);
        load_byte(8'h5A);
        check_buf();
        xmit(2'd0, 30, 10, 1'b0);

`ifdef ROUTER_TX_PARITY_INJ_EN
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
        xmit(2'd1, 0, 100, 1'b1);
`endif

        for (int p = 0; p < 12; p++) begin
            int unsigned n;
            bit          inj;
            n = $urandom_range(1, 24);
            for (int unsigned i = 0; i < n; i++) load_byte(8'($urandom));
            check_buf();
            inj = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj = 1'($urandom_range(0, 1));
`endif
            xmit(2'($urandom_range(0, 2)), 30, 15, inj);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
